y86_mem_loader: RTL and testbench
=================================

// Module: y86_mem_loader
// PURPOSE
//  Memory side of the y86 sequential core: byte-addressed unified instruction/data RAM on the
//  core's bus (addr/RE/WE/wdata -> rdata), plus a boot loader that streams a program image in
//  over a byte handshake while holding the core in reset. It also detects the HALT opcode to
//  freeze the core and counts run cycles. It sits directly below the core on its bus.
// PARAMETERS
//  ADDR_W    12  byte-address width; RAM depth = 2**ADDR_W bytes
//  HOLD_CYC  2   cycles core_rst stays high after the last load byte (>=1)
// PORTS
//  clk            in   1   clock; all state updates on posedge
//  rst            in   1   reset, asynchronous, active-low
//  ld_valid       in   1   loader byte valid
//  ld_data        in   8   loader byte
//  ld_last        in   1   final image byte, qualified by ld_valid
//  ld_ready       out  1   loader may transfer; high only in LOAD
//  core_rst       out  1   synchronous active-high reset to the core
//  cpu_addr       in   32  core bus address (byte)
//  cpu_re         in   1   core read strobe
//  cpu_we         in   1   core write strobe
//  cpu_wdata      in   32  core write data
//  cpu_rdata      out  32  read data, combinational from cpu_addr
//  current_opcode in   8   core's IR[7:0]
//  halted         out  1   sticky, HALT reached
//  err_oob        out  1   sticky, out-of-range access or load overflow
//  cycle_count    out  32  RUN cycles elapsed
// BEHAVIOUR
//  Reset (rst=0, async): state=LOAD, load ptr=0, hold cnt=0, core_rst=1, halted=0, err_oob=0,
//   cycle_count=0. ld_ready=0 while rst=0. RAM contents are not reset.
//  FSM LOAD->HOLD->RUN->HALT. HALT is left only via rst.
//  LOAD: ld_ready=1. On each valid&ready edge: mem[ptr]<=ld_data, ptr++.
//   ptr wraps modulo 2**ADDR_W; a wrap sets err_oob.
//   A handshake with ld_last=1 moves to HOLD. The byte is written in the same edge.
//  HOLD: core_rst=1 for exactly HOLD_CYC cycles, then RUN.
//  RUN: core_rst=0. cycle_count increments each cycle and saturates at 32'hFFFF_FFFF.
//   current_opcode==8'hF4 sampled at an edge -> HALT.
//  HALT: core_rst=1, halted=1, cycle_count frozen. RAM stays readable.
//  Read: cpu_rdata = {mem[a+3],mem[a+2],mem[a+1],mem[a]} (little-endian, unaligned allowed),
//   a=cpu_addr[ADDR_W-1:0]. Byte indices wrap modulo depth. Zero latency; the core latches the
//   data on the same edge. Valid in every state, independent of cpu_re.
//  Write: in RUN only, cpu_we at an edge writes the 4 bytes of cpu_wdata little-endian at a..a+3
//   with the same wrap. cpu_we in other states is ignored.
//  Range: if cpu_addr[31:ADDR_W]!=0, cpu_rdata=0. With cpu_re or cpu_we in RUN, err_oob<=1 and
//   the write is suppressed.
//  Simultaneous cpu_re & cpu_we on one address: rdata shows old data; the new data is visible
//   the next cycle.
//  rst mid-LOAD: the partial image stays in RAM; the reload restarts at ptr 0.
//  rst mid-RUN: core_rst is asserted immediately (async) and is held through LOAD/HOLD.
// STRUCTURE
//  Shared package y86_pkg: OPC_HALT=8'hF4, bus width 32, FSM state enum
//   {LOAD,HOLD,RUN,HALT} (2-bit).
//  Sub-module y86_byte_ram: 2**ADDR_W x 8 array with 4 combinational read lanes and a 4-lane
//   write with a per-lane address. The loader uses lane 0 only.
//  Top: FSM, ptr/hold/cycle counters, range check, address lane generation (a+k mod depth).
// TESTING
//  1 Load 01..06, ld_last on byte 6, ld_valid held high -> ld_ready low the next cycle;
//    core_rst high exactly 2 cycles after the last handshake, then 0;
//    cpu_addr=0 -> 0x04030201; cpu_addr=2 -> 0x06050403.
//  2 RUN, cpu_we addr 0x10 data 0xDEADBEEF -> next cycle addr 0x10 reads 0xDEADBEEF;
//    addr 0x13 low byte = 0xDE; err_oob stays 0.
//  3 Wrap: preload mem[FFE]=AA, [FFF]=BB, [000]=CC, [001]=DD -> addr 0xFFE reads 0xDDCCBBAA;
//    write 0x11223344 at 0xFFF lands 44@FFF, 33@000, 22@001, 11@002.
//  4 RUN, cpu_we addr 0x0000_1000 -> no RAM byte changes, rdata=0, err_oob=1 and stays 1.
//  5 RUN for 37 cycles, then current_opcode=F4 -> next edge halted=1, core_rst=1,
//    cycle_count frozen at its value; cycles later unchanged.
//  6 rst low after 3 of 6 load bytes -> core_rst=1 and ld_ready=0 asynchronously; after release
//    the first byte loads to address 0 and the earlier bytes are overwritten in order.

Source files
------------

// File: rtl/y86_pkg.sv
// rtl/y86_pkg.sv - shared constants and FSM state type for the y86 memory/loader slice
package y86_pkg;

    localparam logic [7:0] OPC_HALT = 8'hF4;
    localparam int         BUS_W    = 32;

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_HOLD = 2'd1,
        ST_RUN  = 2'd2,
        ST_HALT = 2'd3
    } state_e;

endpackage

// File: rtl/y86_byte_ram.sv
// rtl/y86_byte_ram.sv - byte-wide RAM with four combinational read lanes and four write lanes
module y86_byte_ram #(
    parameter int ADDR_W = 12
) (
    input  logic                   clk,
    input  logic [3:0][ADDR_W-1:0] rd_addr,
    output logic [3:0][7:0]        rd_data,
    input  logic [3:0]             wr_en,
    input  logic [3:0][ADDR_W-1:0] wr_addr,
    input  logic [3:0][7:0]        wr_data
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [7:0] mem [DEPTH];

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            rd_data[k] = mem[rd_addr[k]];
        end
    end

    // Lane addresses are distinct modulo depth, so lanes never collide on one byte.
    always_ff @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (wr_en[k]) begin
                mem[wr_addr[k]] <= wr_data[k];
            end
        end
    end

endmodule

// File: rtl/y86_mem_loader.sv
// rtl/y86_mem_loader.sv - unified y86 RAM with boot loader, core reset sequencing and HALT detect
module y86_mem_loader
    import y86_pkg::*;
#(
    parameter int ADDR_W   = 12,
    parameter int HOLD_CYC = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld_valid,
    input  logic [7:0]       ld_data,
    input  logic             ld_last,
    output logic             ld_ready,
    output logic             core_rst,
    input  logic [BUS_W-1:0] cpu_addr,
    input  logic             cpu_re,
    input  logic             cpu_we,
    input  logic [BUS_W-1:0] cpu_wdata,
    output logic [BUS_W-1:0] cpu_rdata,
    input  logic [7:0]       current_opcode,
    output logic             halted,
    output logic             err_oob,
    output logic [31:0]      cycle_count
);

    localparam int                HOLD_W    = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYC - 1);

    state_e              state_q,  state_d;
    logic [ADDR_W-1:0]   ptr_q,    ptr_d;
    logic [HOLD_W-1:0]   hold_q,   hold_d;
    logic                halted_q, halted_d;
    logic                err_q,    err_d;
    logic [31:0]         cyc_q,    cyc_d;

    logic [3:0][ADDR_W-1:0] lane_addr;
    logic [3:0][7:0]        rd_data;
    logic [3:0]             wr_en;
    logic [3:0][ADDR_W-1:0] wr_addr;
    logic [3:0][7:0]        wr_data;
    logic                   in_range;
    logic                   ld_fire;

    assign in_range = (cpu_addr[BUS_W-1:ADDR_W] == '0);
    // ld_ready is gated by rst directly so it drops asynchronously with reset.
    assign ld_ready = rst && (state_q == ST_LOAD);
    assign ld_fire  = ld_valid && ld_ready;
    assign core_rst = (state_q != ST_RUN);

    assign halted      = halted_q;
    assign err_oob     = err_q;
    assign cycle_count = cyc_q;

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            lane_addr[k] = cpu_addr[ADDR_W-1:0] + ADDR_W'(k);
        end
    end

    assign cpu_rdata = in_range ? {rd_data[3], rd_data[2], rd_data[1], rd_data[0]} : '0;

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        hold_d   = hold_q;
        halted_d = halted_q;
        err_d    = err_q;
        cyc_d    = cyc_q;
        wr_en    = '0;
        wr_addr  = lane_addr;
        for (int k = 0; k < 4; k++) begin
            wr_data[k] = cpu_wdata[8*k +: 8];
        end

        case (state_q)
            ST_LOAD: begin
                if (ld_fire) begin
                    wr_en[0]   = 1'b1;
                    wr_addr[0] = ptr_q;
                    wr_data[0] = ld_data;
                    ptr_d      = ptr_q + 1'b1;
                    if (ptr_q == '1) begin
                        err_d = 1'b1;
                    end
                    if (ld_last) begin
                        state_d = ST_HOLD;
                        hold_d  = '0;
                    end
                end
            end
            ST_HOLD: begin
                if (hold_q == HOLD_LAST) begin
                    state_d = ST_RUN;
                    hold_d  = '0;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            ST_RUN: begin
                if (cyc_q != '1) begin
                    cyc_d = cyc_q + 32'd1;
                end
                if ((cpu_re || cpu_we) && !in_range) begin
                    err_d = 1'b1;
                end
                if (cpu_we && in_range) begin
                    wr_en = '1;
                end
                if (current_opcode == OPC_HALT) begin
                    state_d  = ST_HALT;
                    halted_d = 1'b1;
                end
            end
            ST_HALT: begin
            end
            default: begin
                state_d = ST_LOAD;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_LOAD;
            ptr_q    <= '0;
            hold_q   <= '0;
            halted_q <= 1'b0;
            err_q    <= 1'b0;
            cyc_q    <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            hold_q   <= hold_d;
            halted_q <= halted_d;
            err_q    <= err_d;
            cyc_q    <= cyc_d;
        end
    end

    y86_byte_ram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .rd_addr (lane_addr),
        .rd_data (rd_data),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data)
    );

endmodule

// File: tb/tb_y86_mem_loader.sv
// tb/tb_y86_mem_loader.sv - self-checking bench for y86_mem_loader
module tb_y86_mem_loader;

    logic        clk;
    logic        rst;
    logic        ld_valid;
    logic [7:0]  ld_data;
    logic        ld_last;
    logic        ld_ready;
    logic        core_rst;
    logic [31:0] cpu_addr;
    logic        cpu_re;
    logic        cpu_we;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic [7:0]  current_opcode;
    logic        halted;
    logic        err_oob;
    logic [31:0] cycle_count;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_q [$];
    logic [31:0] addr_q [$];
    logic [31:0] exp;

    y86_mem_loader dut (
        .clk            (clk),
        .rst            (rst),
        .ld_valid       (ld_valid),
        .ld_data        (ld_data),
        .ld_last        (ld_last),
        .ld_ready       (ld_ready),
        .core_rst       (core_rst),
        .cpu_addr       (cpu_addr),
        .cpu_re         (cpu_re),
        .cpu_we         (cpu_we),
        .cpu_wdata      (cpu_wdata),
        .cpu_rdata      (cpu_rdata),
        .current_opcode (current_opcode),
        .halted         (halted),
        .err_oob        (err_oob),
        .cycle_count    (cycle_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Streams n bytes base, base+1, ...; returns 1ns after the last handshake edge.
    task automatic drive_load(input logic [7:0] base, input int n, input bit last);
        for (int i = 0; i < n; i++) begin
            ld_valid = 1'b1;
            ld_data  = base + 8'(i);
            ld_last  = last && (i == n - 1);
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0;
        cpu_addr = '0; cpu_re = 1'b0; cpu_we = 1'b0; cpu_wdata = '0; current_opcode = '0;
        #3;
        total++; if (ld_ready !== 1'b0) begin bad++; $display("FAIL rst_ld_ready got=%b want=0", ld_ready); end
        total++; if (core_rst !== 1'b1) begin bad++; $display("FAIL rst_core_rst got=%b want=1", core_rst); end
        total++; if (halted !== 1'b0) begin bad++; $display("FAIL rst_halted got=%b want=0", halted); end
        total++; if (err_oob !== 1'b0) begin bad++; $display("FAIL rst_err got=%b want=0", err_oob); end
        total++; if (cycle_count !== 32'd0) begin bad++; $display("FAIL rst_cycles got=%0d want=0", cycle_count); end
        tick();
        rst = 1'b1;
        #1;
        total++; if (ld_ready !== 1'b1) begin bad++; $display("FAIL load_ready got=%b want=1", ld_ready); end
    endtask

    task automatic test_load();
        drive_load(8'h01, 6, 1'b1);
        total++; if (ld_ready !== 1'b0) begin bad++; $display("FAIL ready_drop got=%b want=0", ld_ready); end
        total++; if (core_rst !== 1'b1) begin bad++; $display("FAIL hold_c0 got=%b want=1", core_rst); end
        tick();
        total++; if (core_rst !== 1'b1) begin bad++; $display("FAIL hold_c1 got=%b want=1", core_rst); end
        tick();
        total++; if (core_rst !== 1'b0) begin bad++; $display("FAIL run_core_rst got=%b want=0", core_rst); end
        ld_valid = 1'b0; ld_last = 1'b0;
        addr_q.push_back(32'h0); exp_q.push_back(32'h0403_0201);
        addr_q.push_back(32'h2); exp_q.push_back(32'h0605_0403);
        while (exp_q.size() > 0) begin
            cpu_addr = addr_q.pop_front();
            #1;
            exp = exp_q.pop_front();
            total++; if (cpu_rdata !== exp) begin bad++; $display("FAIL load_rd addr=%h got=%h want=%h", cpu_addr, cpu_rdata, exp); end
        end
    endtask

    task automatic test_run_write();
        cpu_addr = 32'h10; cpu_wdata = 32'hDEAD_BEEF; cpu_we = 1'b1;
        exp_q.push_back(32'hDEAD_BEEF);
        tick();
        cpu_we = 1'b0;
        #1;
        exp = exp_q.pop_front();
        total++; if (cpu_rdata !== exp) begin bad++; $display("FAIL wr_rd got=%h want=%h", cpu_rdata, exp); end
        cpu_addr = 32'h13;
        exp_q.push_back(32'h0000_00DE);
        #1;
        exp = exp_q.pop_front();
        total++; if (cpu_rdata[7:0] !== exp[7:0]) begin bad++; $display("FAIL wr_rd13 got=%h want=%h", cpu_rdata[7:0], exp[7:0]); end
        total++; if (err_oob !== 1'b0) begin bad++; $display("FAIL wr_err got=%b want=0", err_oob); end
    endtask

    task automatic test_wrap();
        cpu_addr = 32'hFFE; cpu_wdata = 32'hDDCC_BBAA; cpu_we = 1'b1;
        tick();
        cpu_we = 1'b0;
        addr_q.push_back(32'hFFE); exp_q.push_back(32'hDDCC_BBAA);
        addr_q.push_back(32'h000); exp_q.push_back(32'h0403_DDCC);
        while (exp_q.size() > 0) begin
            cpu_addr = addr_q.pop_front();
            #1;
            exp = exp_q.pop_front();
            total++; if (cpu_rdata !== exp) begin bad++; $display("FAIL wrap_rd addr=%h got=%h want=%h", cpu_addr, cpu_rdata, exp); end
        end
        cpu_addr = 32'hFFF; cpu_wdata = 32'h1122_3344; cpu_we = 1'b1; cpu_re = 1'b1;
        exp_q.push_back(32'h03DD_CCBB);
        #1;
        exp = exp_q.pop_front();
        total++; if (cpu_rdata !== exp) begin bad++; $display("FAIL rw_old got=%h want=%h", cpu_rdata, exp); end
        tick();
        cpu_we = 1'b0; cpu_re = 1'b0;
        addr_q.push_back(32'hFFF); exp_q.push_back(32'h1122_3344);
        addr_q.push_back(32'hFFE); exp_q.push_back(32'h2233_44AA);
        addr_q.push_back(32'h002); exp_q.push_back(32'h0605_0411);
        while (exp_q.size() > 0) begin
            cpu_addr = addr_q.pop_front();
            #1;
            exp = exp_q.pop_front();
            total++; if (cpu_rdata !== exp) begin bad++; $display("FAIL wrap_wr addr=%h got=%h want=%h", cpu_addr, cpu_rdata, exp); end
        end
        total++; if (err_oob !== 1'b0) begin bad++; $display("FAIL wrap_err got=%b want=0", err_oob); end
    endtask

    task automatic test_oob();
        cpu_addr = 32'h0000_1000; cpu_wdata = 32'h5566_7788; cpu_we = 1'b1;
        #1;
        total++; if (cpu_rdata !== 32'h0) begin bad++; $display("FAIL oob_rd got=%h want=0", cpu_rdata); end
        tick();
        cpu_we = 1'b0;
        total++; if (err_oob !== 1'b1) begin bad++; $display("FAIL oob_err got=%b want=1", err_oob); end
        cpu_addr = 32'h0;
        exp_q.push_back(32'h0411_2233);
        #1;
        exp = exp_q.pop_front();
        total++; if (cpu_rdata !== exp) begin bad++; $display("FAIL oob_nowrite got=%h want=%h", cpu_rdata, exp); end
        for (int i = 0; i < 3; i++) tick();
        total++; if (err_oob !== 1'b1) begin bad++; $display("FAIL oob_sticky got=%b want=1", err_oob); end
    endtask

    task automatic test_reload();
        #2;
        rst = 1'b0;
        #1;
        total++; if (core_rst !== 1'b1) begin bad++; $display("FAIL arst_core got=%b want=1", core_rst); end
        total++; if (ld_ready !== 1'b0) begin bad++; $display("FAIL arst_ready got=%b want=0", ld_ready); end
        total++; if (err_oob !== 1'b0) begin bad++; $display("FAIL arst_err got=%b want=0", err_oob); end
        total++; if (cycle_count !== 32'd0) begin bad++; $display("FAIL arst_cyc got=%0d want=0", cycle_count); end
        tick();
        rst = 1'b1;
        drive_load(8'hA1, 3, 1'b0);
        ld_valid = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        total++; if (ld_ready !== 1'b0) begin bad++; $display("FAIL midld_ready got=%b want=0", ld_ready); end
        total++; if (core_rst !== 1'b1) begin bad++; $display("FAIL midld_core got=%b want=1", core_rst); end
        tick();
        rst = 1'b1;
        drive_load(8'hB1, 6, 1'b1);
        tick();
        tick();
        ld_valid = 1'b0; ld_last = 1'b0;
        total++; if (core_rst !== 1'b0) begin bad++; $display("FAIL reload_run got=%b want=0", core_rst); end
        addr_q.push_back(32'h0); exp_q.push_back(32'hB4B3_B2B1);
        addr_q.push_back(32'h2); exp_q.push_back(32'hB6B5_B4B3);
        while (exp_q.size() > 0) begin
            cpu_addr = addr_q.pop_front();
            #1;
            exp = exp_q.pop_front();
            total++; if (cpu_rdata !== exp) begin bad++; $display("FAIL reload_rd addr=%h got=%h want=%h", cpu_addr, cpu_rdata, exp); end
        end
        total++; if (cycle_count !== 32'd0) begin bad++; $display("FAIL run_start got=%0d want=0", cycle_count); end
    endtask

    task automatic test_halt();
        current_opcode = 8'h00;
        for (int i = 0; i < 37; i++) tick();
        total++; if (cycle_count !== 32'd37) begin bad++; $display("FAIL run37 got=%0d want=37", cycle_count); end
        total++; if (halted !== 1'b0) begin bad++; $display("FAIL prehalt got=%b want=0", halted); end
        current_opcode = 8'hF4;
        tick();
        current_opcode = 8'h00;
        total++; if (halted !== 1'b1) begin bad++; $display("FAIL halt got=%b want=1", halted); end
        total++; if (core_rst !== 1'b1) begin bad++; $display("FAIL halt_core got=%b want=1", core_rst); end
        total++; if (cycle_count !== 32'd38) begin bad++; $display("FAIL halt_cyc got=%0d want=38", cycle_count); end
        cpu_addr = 32'h0; cpu_wdata = 32'hFFFF_FFFF; cpu_we = 1'b1;
        exp_q.push_back(32'hB4B3_B2B1);
        tick();
        cpu_we = 1'b0;
        #1;
        exp = exp_q.pop_front();
        total++; if (cpu_rdata !== exp) begin bad++; $display("FAIL halt_nowr got=%h want=%h", cpu_rdata, exp); end
        for (int i = 0; i < 5; i++) tick();
        total++; if (cycle_count !== 32'd38) begin bad++; $display("FAIL halt_frozen got=%0d want=38", cycle_count); end
        total++; if (halted !== 1'b1) begin bad++; $display("FAIL halt_sticky got=%b want=1", halted); end
    endtask

    initial begin
        test_reset();
        test_load();
        test_run_write();
        test_wrap();
        test_oob();
        test_reload();
        test_halt();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
